// File: rtl/salu_pkg.sv
// Shared operation codes, FSM states, flag bundle and decode helpers for the scalar ALU pipe.
package salu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_BEQ    = 5'd10,
        OP_BNE    = 5'd11,
        OP_BLT    = 5'd12,
        OP_BGE    = 5'd13,
        OP_BLTU   = 5'd14,
        OP_BGEU   = 5'd15,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } salu_state_e;

    typedef struct packed {
        logic zero;
        logic negative;
        logic overflow;
        logic dbz;
    } salu_flags_t;

    function automatic logic is_branch(input logic [4:0] op);
        return (op >= 5'd10) && (op <= 5'd15);
    endfunction

    // Codes 24..31 are undefined and fall back to the base path.
    function automatic logic is_mdu(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/salu_mdu.sv
// Iterative multiply/divide engine: radix-2 shift-add multiplier and restoring divider sharing one accumulator.
module salu_mdu
    import salu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  start_i,
    input  alu_op_e               op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  dbz_o,
    output logic                  overflow_o
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned W1    = DATA_WIDTH + 1;
    localparam int unsigned W2    = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic [W2-1:0]    acc_q, acc_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             is_div_q, is_div_d;
    logic             sel_hi_q, sel_hi_d;
    logic             neg_q, neg_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [W-1:0]     result_q, result_d;

    logic          a_sgn_c, b_sgn_c, sa_c, sb_c, div_c;
    logic [W-1:0]  a_mag_c, b_mag_c;
    logic [W1-1:0] mul_sum_c, div_shift_c, div_diff_c;
    logic [W2-1:0] acc_nx_c, prod_c;
    logic [W-1:0]  part_c, fin_c;

    // Operand decode at start: signed variants iterate on magnitudes.
    always_comb begin
        a_sgn_c = op_i inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_sgn_c = op_i inside {OP_MULH, OP_DIV, OP_REM};
        div_c   = op_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        sa_c    = a_sgn_c && a_i[W-1];
        sb_c    = b_sgn_c && b_i[W-1];
        a_mag_c = sa_c ? W'(0) - a_i : a_i;
        b_mag_c = sb_c ? W'(0) - b_i : b_i;
    end

    // One iteration step plus the sign fix-up applied after the last step.
    always_comb begin
        mul_sum_c   = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : W1'(0));
        div_shift_c = {acc_q[W2-1:W], acc_q[W-1]};
        div_diff_c  = div_shift_c - {1'b0, opnd_q};
        if (is_div_q) begin
            acc_nx_c = div_diff_c[W] ? {div_shift_c[W-1:0], acc_q[W-2:0], 1'b0}
                                     : {div_diff_c[W-1:0],  acc_q[W-2:0], 1'b1};
        end else begin
            acc_nx_c = {mul_sum_c, acc_q[W-1:1]};
        end
        prod_c = neg_q ? W2'(0) - acc_nx_c : acc_nx_c;
        part_c = sel_hi_q ? acc_nx_c[W2-1:W] : acc_nx_c[W-1:0];
        if (is_div_q) begin
            fin_c = neg_q ? W'(0) - part_c : part_c;
            if (dbz_q && !sel_hi_q) begin
                fin_c = '1;
            end
        end else begin
            fin_c = sel_hi_q ? prod_c[W2-1:W] : prod_c[W-1:0];
        end
    end

    always_comb begin
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        is_div_d = is_div_q;
        sel_hi_d = sel_hi_q;
        neg_d    = neg_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        result_d = result_q;
        if (start_i) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            is_div_d = div_c;
            sel_hi_d = !(op_i inside {OP_MUL, OP_DIV, OP_DIVU});
            neg_d    = (op_i == OP_REM) ? sa_c : (sa_c ^ sb_c);
            dbz_d    = div_c && (b_i == '0);
            ovf_d    = (op_i inside {OP_DIV, OP_REM}) && (a_i == MOST_NEG) && (b_i == '1);
            if (div_c) begin
                acc_d  = {W'(0), a_mag_c};
                opnd_d = b_mag_c;
            end else begin
                acc_d  = {W'(0), b_mag_c};
                opnd_d = a_mag_c;
            end
        end else if (run_q) begin
            acc_d = acc_nx_c;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                run_d    = 1'b0;
                done_d   = 1'b1;
                result_d = fin_c;
            end
        end
        if (flush_i) begin
            run_d  = 1'b0;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            is_div_q <= 1'b0;
            sel_hi_q <= 1'b0;
            neg_q    <= 1'b0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            is_div_q <= is_div_d;
            sel_hi_q <= sel_hi_d;
            neg_q    <= neg_d;
            dbz_q    <= dbz_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign done_o     = done_q;
    assign result_o   = result_q;
    assign dbz_o      = dbz_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/salu_pipe.sv
// Scalar ALU pipe stage: base ALU/branch ops in one cycle, M-ops via the iterative engine, registered result with valid/ready.
module salu_pipe
    import salu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [4:0]            op_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] alu_res_o,
    output logic [TAG_WIDTH-1:0]  tag_o,
    output logic                  zero_flag_o,
    output logic                  negative_flag_o,
    output logic                  overflow_flag_o,
    output logic                  dbz_flag_o
);

    localparam int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH);
    localparam int unsigned MSB         = DATA_WIDTH - 1;

    salu_state_e           state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [TAG_WIDTH-1:0]  busy_tag_q, busy_tag_d;
    salu_flags_t           flags_q, flags_d;

    alu_op_e                op_c;
    logic                   accept_c;
    logic [DATA_WIDTH-1:0]  sum_c, diff_c, base_res_c;
    logic [SHAMT_WIDTH-1:0] shamt_c;
    logic                   taken_c, ovf_c;
    salu_flags_t            base_flags_c;

    logic                  mdu_done;
    logic [DATA_WIDTH-1:0] mdu_res;
    logic                  mdu_dbz, mdu_ovf;

    assign op_c       = alu_op_e'(op_i);
    assign in_ready_o = (state_q == ST_IDLE) && (!out_valid_q || out_ready_i) && !flush_i;
    assign accept_c   = in_valid_i && in_ready_o;

    // Base ALU and branch comparator.
    always_comb begin
        sum_c      = rs1_data_i + rs2_data_i;
        diff_c     = rs1_data_i - rs2_data_i;
        shamt_c    = rs2_data_i[SHAMT_WIDTH-1:0];
        taken_c    = 1'b0;
        ovf_c      = 1'b0;
        base_res_c = '0;
        case (op_c)
            OP_ADD: begin
                base_res_c = sum_c;
                ovf_c = (rs1_data_i[MSB] == rs2_data_i[MSB]) && (sum_c[MSB] != rs1_data_i[MSB]);
            end
            OP_SUB: begin
                base_res_c = diff_c;
                ovf_c = (rs1_data_i[MSB] != rs2_data_i[MSB]) && (diff_c[MSB] != rs1_data_i[MSB]);
            end
            OP_SLL:  base_res_c = rs1_data_i << shamt_c;
            OP_SLT:  base_res_c = DATA_WIDTH'($signed(rs1_data_i) < $signed(rs2_data_i));
            OP_SLTU: base_res_c = DATA_WIDTH'(rs1_data_i < rs2_data_i);
            OP_XOR:  base_res_c = rs1_data_i ^ rs2_data_i;
            OP_SRL:  base_res_c = rs1_data_i >> shamt_c;
            OP_SRA:  base_res_c = DATA_WIDTH'($signed(rs1_data_i) >>> shamt_c);
            OP_OR:   base_res_c = rs1_data_i | rs2_data_i;
            OP_AND:  base_res_c = rs1_data_i & rs2_data_i;
            OP_BEQ:  taken_c = (rs1_data_i == rs2_data_i);
            OP_BNE:  taken_c = (rs1_data_i != rs2_data_i);
            OP_BLT:  taken_c = ($signed(rs1_data_i) < $signed(rs2_data_i));
            OP_BGE:  taken_c = ($signed(rs1_data_i) >= $signed(rs2_data_i));
            OP_BLTU: taken_c = (rs1_data_i < rs2_data_i);
            OP_BGEU: taken_c = (rs1_data_i >= rs2_data_i);
            default: base_res_c = '0;
        endcase
        if (is_branch(op_i)) begin
            base_res_c = DATA_WIDTH'(taken_c);
        end
        base_flags_c.zero     = is_branch(op_i) ? taken_c : (base_res_c == '0);
        base_flags_c.negative = base_res_c[MSB];
        base_flags_c.overflow = ovf_c;
        base_flags_c.dbz      = 1'b0;
    end

    salu_mdu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mdu (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .start_i    (accept_c && is_mdu(op_i)),
        .op_i       (op_c),
        .a_i        (rs1_data_i),
        .b_i        (rs2_data_i),
        .done_o     (mdu_done),
        .result_o   (mdu_res),
        .dbz_o      (mdu_dbz),
        .overflow_o (mdu_ovf)
    );

    // Handshake FSM and output register next-state.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        tag_d       = tag_q;
        flags_d     = flags_q;
        busy_tag_d  = busy_tag_q;
        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (is_mdu(op_i)) begin
                        state_d    = ST_BUSY;
                        busy_tag_d = tag_i;
                    end else begin
                        out_valid_d = 1'b1;
                        res_d       = base_res_c;
                        tag_d       = tag_i;
                        flags_d     = base_flags_c;
                    end
                end
            end
            ST_BUSY: begin
                if (mdu_done) begin
                    state_d          = ST_IDLE;
                    out_valid_d      = 1'b1;
                    res_d            = mdu_res;
                    tag_d            = busy_tag_q;
                    flags_d.zero     = (mdu_res == '0);
                    flags_d.negative = mdu_res[MSB];
                    flags_d.overflow = mdu_ovf;
                    flags_d.dbz      = mdu_dbz;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            tag_q       <= '0;
            flags_q     <= '0;
            busy_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            tag_q       <= tag_d;
            flags_q     <= flags_d;
            busy_tag_q  <= busy_tag_d;
        end
    end

    assign out_valid_o     = out_valid_q;
    assign alu_res_o       = res_q;
    assign tag_o           = tag_q;
    assign zero_flag_o     = flags_q.zero;
    assign negative_flag_o = flags_q.negative;
    assign overflow_flag_o = flags_q.overflow;
    assign dbz_flag_o      = flags_q.dbz;

endmodule

// File: tb/tb_salu_pipe.sv
// Scoreboard bench for salu_pipe: directed ops push expected results, a monitor checks each delivered result.
module tb_salu_pipe;
    import salu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic [3:0]  flags; // {zero, negative, overflow, dbz}
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  op_in, tag_in, tag_out;
    logic [31:0] rs1, rs2, res;
    logic        zf, nf, of, df;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    salu_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .op_i            (op_in),
        .rs1_data_i      (rs1),
        .rs2_data_i      (rs2),
        .tag_i           (tag_in),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .alu_res_o       (res),
        .tag_o           (tag_out),
        .zero_flag_o     (zf),
        .negative_flag_o (nf),
        .overflow_flag_o (of),
        .dbz_flag_o      (df)
    );

    function automatic exp_t mk(input logic [31:0] r, input logic [4:0] t, input logic [3:0] f);
        exp_t e;
        e.res = r; e.tag = t; e.flags = f;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Offer one op (call at posedge+1); returns how many cycles it waited for in_ready.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input bit push, input exp_t e, output int waited);
        in_valid = 1'b1; op_in = op; rs1 = a; rs2 = b; tag_in = t;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        if (push && in_ready) sb.push_back(e);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: compare every transferred result against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", res, 32'hDEAD_BEEF);
                end else begin
                    e = sb.pop_front();
                    chk("result", res, e.res);
                    chk("tag", 32'(tag_out), 32'(e.tag));
                    chk("flags_znod", 32'({zf, nf, of, df}), 32'(e.flags));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w, stalls, n;
        exp_t nil;
        nil = mk(32'd0, 5'd0, 4'b0);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op_in = '0; rs1 = '0; rs2 = '0; tag_in = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_res", res, 32'd0);
        chk("rst_tag", 32'(tag_out), 32'd0);
        chk("rst_flags", 32'({zf, nf, of, df}), 32'd0);
        @(posedge clk); #1;

        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd7, 1'b1, mk(32'h8000_0000, 5'd7, 4'b0110), w);

        // Back-to-back base ops must not stall.
        stalls = 0;
        issue(OP_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd1, 1'b1, mk(32'hFF00_FF00, 5'd1, 4'b0100), w); stalls += w;
        issue(OP_SRA,  32'hF000_0000, 32'd4,         5'd2, 1'b1, mk(32'hFF00_0000, 5'd2, 4'b0100), w); stalls += w;
        issue(OP_BLTU, 32'd1,         32'd2,         5'd3, 1'b1, mk(32'd1,         5'd3, 4'b1000), w); stalls += w;
        issue(OP_SLL,  32'd1,         32'd31,        5'd4, 1'b1, mk(32'h8000_0000, 5'd4, 4'b0100), w); stalls += w;
        issue(OP_SRL,  32'h8000_0000, 32'h24,        5'd5, 1'b1, mk(32'h0800_0000, 5'd5, 4'b0000), w); stalls += w;
        issue(OP_BGE,  32'hFFFF_FFFF, 32'd1,         5'd6, 1'b1, mk(32'd0,         5'd6, 4'b0000), w); stalls += w;
        in_valid = 1'b0;
        chk("stream_stalls", 32'(stalls), 32'd0);

        // M-op latency: in_ready low for DATA_WIDTH+1 cycles.
        issue(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b1, mk(32'd0, 5'd8, 4'b1000), w);
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("mdu_busy_cycles", 32'(n), 32'd33);
        @(posedge clk); #1;

        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  1'b1, mk(32'hFFFF_FFFE, 5'd9,  4'b0100), w);
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b1, mk(32'h8000_0000, 5'd10, 4'b0110), w);
        issue(OP_DIVU,  32'd100,       32'd0,         5'd11, 1'b1, mk(32'hFFFF_FFFF, 5'd11, 4'b0101), w);
        issue(OP_REM,   32'hFFFF_FFF9, 32'd2,         5'd12, 1'b1, mk(32'hFFFF_FFFF, 5'd12, 4'b0100), w);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,         5'd13, 1'b1, mk(32'hFFFF_FFFD, 5'd13, 4'b0100), w);
        issue(OP_MUL,   32'hFFFF_FFF9, 32'd3,         5'd14, 1'b1, mk(32'hFFFF_FFEB, 5'd14, 4'b0100), w);
        issue(OP_REMU,  32'd100,       32'd0,         5'd15, 1'b1, mk(32'd100,       5'd15, 4'b0001), w);
        issue(5'd24,    32'd5,         32'd5,         5'd16, 1'b1, mk(32'd0,         5'd16, 4'b1000), w);
        in_valid = 1'b0;
        drain();

        // Backpressure: result held, input blocked, then drain and accept in one edge.
        out_ready = 1'b0;
        issue(OP_SUB, 32'h8000_0000, 32'd1, 5'd17, 1'b1, mk(32'h7FFF_FFFF, 5'd17, 4'b0010), w);
        in_valid = 1'b1; op_in = OP_ADD; rs1 = 32'd10; rs2 = 32'd20; tag_in = 5'd18;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_res", res, 32'h7FFF_FFFF);
            chk("hold_tag", 32'(tag_out), 32'd17);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("drain_accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        sb.push_back(mk(32'd30, 5'd18, 4'b0000));
        #1 in_valid = 1'b0;
        drain();

        // Flush mid-divide, with an op offered during the flush cycle.
        issue(OP_DIVU, 32'h0000_1234, 32'd7, 5'd21, 1'b0, nil, w);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        in_valid = 1'b1; op_in = OP_ADD; rs1 = 32'd1; rs2 = 32'd1; tag_in = 5'd22;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_idle_ready", 32'(in_ready), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        issue(OP_ADD, 32'd2, 32'd3, 5'd19, 1'b1, mk(32'd5, 5'd19, 4'b0000), w);
        in_valid = 1'b0;
        drain();

        // Reset mid-multiply.
        issue(OP_MUL, 32'h0000_1234, 32'h0000_5678, 5'd23, 1'b0, nil, w);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_res", res, 32'd0);
        chk("midrst_tag", 32'(tag_out), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        issue(OP_ADD, 32'd2, 32'd3, 5'd20, 1'b1, mk(32'd5, 5'd20, 4'b0000), w);
        in_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/salu_pipe.md
Name: salu_pipe

Overview:
- Next-generation scalar ALU for the core, generalised in `DATA_WIDTH`.
- Adds a valid/ready handshake on both sides, a registered result stage and an iterative multiply/divide engine (RV32M semantics) alongside the existing ALU/branch operation set.
- Sits between issue and writeback in the scalar pipe; the tag carries the destination register index.

Parameters:
- `DATA_WIDTH`, 32, operand/result width; must be a power of two, ≥ 8.
- `TAG_WIDTH`, 5, width of the sideband tag passed from input to result unchanged.
- `SHAMT_WIDTH`, `$clog2(DATA_WIDTH)`, shift-amount bits taken from `rs2`; derived, not overridden.

Ports:
- `clk_i`  input  1  clock
- `rst_i`  input  1  synchronous active-high reset
- `flush_i`  input  1  kill any in-flight or held operation
- `in_valid_i`  input  1  operation offered
- `in_ready_o`  output  1  operation accepted when valid and ready are both high
- `op_i`  input  5  operation code; `op_i[4]=0` selects the base ALU/branch set, `op_i[4]=1` selects M-ops
- `rs1_data_i`  input  `DATA_WIDTH`  operand A
- `rs2_data_i`  input  `DATA_WIDTH`  operand B
- `tag_i`  input  `TAG_WIDTH`  sideband tag
- `out_valid_o`  output  1  result held
- `out_ready_i`  input  1  consumer takes the result
- `alu_res_o`  output  `DATA_WIDTH`  result
- `tag_o`  output  `TAG_WIDTH`  tag of the result
- `zero_flag_o`  output  1  zero / branch-taken flag
- `negative_flag_o`  output  1  result MSB
- `overflow_flag_o`  output  1  ADD/SUB signed overflow, or DIV/REM signed overflow
- `dbz_flag_o`  output  1  divide by zero (DIV/DIVU/REM/REMU only)

Behaviour:
- Reset (`rst_i` sampled high on a clock edge):
  - state IDLE; `out_valid_o`=0; `alu_res_o`, `tag_o` and all flags = 0; counter = 0.
  - Reset wins over every other input, including mid-iteration.
- `in_ready_o` = (state==IDLE) && (!`out_valid_o` || `out_ready_i`) && !`flush_i`. It is combinational; it never depends on `in_valid_i`.
- Base ops, 0..15, encoded as ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, BEQ, BNE, BLT, BGE, BLTU, BGEU:
  - Arithmetic, flags and branch semantics are identical to the current scalar ALU, widened to `DATA_WIDTH`.
  - Shifts use `rs2[SHAMT_WIDTH-1:0]`.
  - Latency 1: accepted at edge N → `out_valid_o`=1 after edge N+1's update, i.e. visible in cycle N+1.
- M-ops, 16..23, encoded as MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU:
  - State IDLE→BUSY on accept.
  - Signed variants convert operands to magnitude; the sign is recorded.
  - MUL*: radix-2 shift-add over a 2×`DATA_WIDTH` accumulator. DIV/REM: restoring divider.
  - One iteration per cycle; counter runs 0..`DATA_WIDTH`-1.
  - After the last iteration: sign fix-up, result and flags written to the output register, `out_valid_o`=1, state→IDLE.
  - Total latency `DATA_WIDTH`+1 cycles from accept to `out_valid_o` (33 for 32-bit).
  - The output register is guaranteed empty during BUSY, because accept required it to be draining.
- Divide by zero:
  - quotient = all ones; remainder = dividend; `dbz_flag_o`=1; `overflow_flag_o`=0.
  - The result is produced on the normal schedule, with no early exit.
- Signed overflow (most-negative ÷ −1): quotient = most-negative; remainder = 0; `overflow_flag_o`=1.
- Flags for M-ops:
  - `zero_flag_o` = (result==0); `negative_flag_o` = result MSB.
  - `overflow_flag_o`=0 except the DIV/REM overflow case above.
- Output hold:
  - While `out_valid_o` && !`out_ready_i`, the result, tag and flags are stable.
  - Same-cycle drain and accept of a base op is allowed: back-to-back throughput is 1 per cycle.
- `flush_i`:
  - Synchronous; next edge sets `out_valid_o`=0 and state IDLE, abandoning any iteration.
  - An input offered in the same cycle is not accepted.
- Undefined op codes: result 0; base-op flag rules apply; latency 1.
- Registered outputs only; there is no combinational path from the inputs to `alu_res_o`.

Decomposition:
- Package `salu_pkg`:
  - `alu_op_e` enum (5-bit, all 24 codes).
  - Helper functions `is_branch(op)` and `is_mdu(op)`.
- Sub-module `salu_mdu`:
  - Owns the iterative multiply/divide datapath, counter, sign handling and corner cases.
  - Interface: start/done pulse, operands, op, result, dbz and overflow outputs.
- Top level: combinational base ALU, handshake control, FSM and output register.

Test Plan:
- Reset, then ADD 0x7FFFFFFF+1 with `out_ready`=1 → cycle later `out_valid`=1, res 0x80000000, overflow=1, negative=1; tag echoes 5'd7.
- Stream 4 back-to-back base ops (XOR, SRA 0xF0000000>>>4, BLTU 1<2, SLL 1<<31) with `out_ready`=1 → `in_ready` stays 1, results 1/cycle: expected XOR result, 0xFF000000, res 1 with zero=1, 0x80000000.
- MULH 0xFFFFFFFF×0xFFFFFFFF → `in_ready`=0 for 33 cycles, res 0x00000000; then MULHU same operands → res 0xFFFFFFFE.
- DIV 0x80000000 by 0xFFFFFFFF → res 0x80000000, overflow=1; DIVU 100 by 0 → res 0xFFFFFFFF, dbz=1; REM −7 by 2 → 0xFFFFFFFF.
- Backpressure: `out_ready`=0 for 5 cycles after a SUB result → output stable, `in_ready`=0; release → next accept in the same cycle as drain.
- Assert `flush_i` at iteration 10 of a DIVU, and separately assert `rst_i` mid-MUL → next cycle IDLE, `out_valid`=0, `in_ready`=1; a following ADD 2+3 returns 5.
